// File: rtl/sram_1w_loader.sv
// Write-side loader for the input buffer SRAM. It accepts a byte stream over
// a valid/ready handshake and writes each byte to sequential addresses,
// starting at a programmable base and wrapping modulo the buffer depth.
// All SRAM write-port outputs are registered. Done pulses for one cycle
// once the final write has been issued.
module sram_1w_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddress,
  input  logic [LEN_W-1:0]  Length,
  input  logic [DATA_W-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteBus,
  output logic              WriteEnable,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  Count,
  output logic [DATA_W-1:0] Checksum
);

  localparam int              DEPTH_I = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] DEPTH   = LEN_W'(DEPTH_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  csum_q, csum_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;

  logic [LEN_W-1:0]   len_clamped;
  logic               ready;
  logic               xfer;

  // Lengths beyond the buffer depth load the whole buffer exactly once.
  assign len_clamped = (Length > DEPTH) ? DEPTH : Length;

  // Ready depends only on registered state, so there is no InValid->InReady path.
  assign ready = (state_q == LOAD) && (rem_q != '0);
  assign xfer  = ready && InValid;

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    count_d = count_q;
    csum_d  = csum_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          ptr_d   = BaseAddress;
          rem_d   = len_clamped;
          count_d = '0;
          csum_d  = '0;
          state_d = (len_clamped != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (xfer) begin
          waddr_d = ptr_q;
          wdata_d = InData;
          we_d    = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          count_d = count_q + LEN_W'(1);
          csum_d  = csum_q + InData;
        end
        // Leave one cycle after the last handshake so the final write issues in LOAD.
        if (rem_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      csum_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign InReady      = ready;
  assign WriteAddress = waddr_q;
  assign WriteBus     = wdata_q;
  assign WriteEnable  = we_q;
  assign Busy         = (state_q != IDLE);
  assign Done         = (state_q == DONE);
  assign Count        = count_q;
  assign Checksum     = csum_q;

endmodule

// File: tb/tb_sram_1w_loader.sv
// Directed bench for sram_1w_loader: each task drives one scenario and
// compares observed writes, handshakes and status against hand-computed values.
module tb_sram_1w_loader;

  logic        clock;
  logic        reset_n;
  logic        Start;
  logic [9:0]  BaseAddress;
  logic [10:0] Length;
  logic [7:0]  InData;
  logic        InValid;
  logic        InReady;
  logic [9:0]  WriteAddress;
  logic [7:0]  WriteBus;
  logic        WriteEnable;
  logic        Busy;
  logic        Done;
  logic [10:0] Count;
  logic [7:0]  Checksum;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          wr_addr[$];
  int          wr_data[$];
  int          wr_cyc[$];
  int          hs_cyc[$];
  int          done_cyc[$];

  sram_1w_loader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .Start        (Start),
    .BaseAddress  (BaseAddress),
    .Length       (Length),
    .InData       (InData),
    .InValid      (InValid),
    .InReady      (InReady),
    .WriteAddress (WriteAddress),
    .WriteBus     (WriteBus),
    .WriteEnable  (WriteEnable),
    .Busy         (Busy),
    .Done         (Done),
    .Count        (Count),
    .Checksum     (Checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log write strobes, handshakes and Done pulses mid-cycle.
  always @(negedge clock) begin
    if (WriteEnable === 1'b1) begin
      wr_addr.push_back(int'(WriteAddress));
      wr_data.push_back(int'(WriteBus));
      wr_cyc.push_back(cyc);
    end
    if (InValid === 1'b1 && InReady === 1'b1) hs_cyc.push_back(cyc);
    if (Done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    hs_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic start_pulse(input int base, input int len);
    Start       = 1'b1;
    BaseAddress = 10'(base);
    Length      = 11'(len);
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    InData  = d;
    InValid = 1'b1;
    while (InReady !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (InReady !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: InReady=%b required 1 within 50 cycles", InReady);
    end
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: Busy=%b required 0 within 40 cycles", Busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if ({InReady, WriteEnable, Busy, Done} !== 4'b0000 || WriteAddress !== 10'd0 ||
        WriteBus !== 8'd0 || Count !== 11'd0 || Checksum !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b addr=%0d bus=%0h cnt=%0d sum=%0h required all 0",
               InReady, WriteEnable, Busy, Done, WriteAddress, WriteBus, Count, Checksum);
    end
    tick();
    tick();
    reset_n = 1'b1;
    clear_logs();
    repeat (10) tick();
    checks++;
    if (wr_addr.size() != 0 || done_cyc.size() != 0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: writes=%0d dones=%0d busy=%b required 0 0 0",
               wr_addr.size(), done_cyc.size(), Busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d[4];
    int k;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    start_pulse(0, 4);
    for (int i = 0; i < 4; i++) send_byte(d[i]);
    InValid = 1'b0;
    k = hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] : -100;
    // Cycle k+1: final write in flight, no more room.
    checks++;
    if (InReady !== 1'b0 || WriteEnable !== 1'b1 || Done !== 1'b0) begin
      failures++;
      $display("FAIL basic_k1: rdy=%b we=%b done=%b required 0 1 0", InReady, WriteEnable, Done);
    end
    wait_idle();
    checks++;
    if (wr_addr.size() != 4 || hs_cyc.size() != 4) begin
      failures++;
      $display("FAIL basic_count: writes=%0d hs=%0d required 4 4", wr_addr.size(), hs_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[i] != i || wr_data[i] != int'(d[i]) || wr_cyc[i] != hs_cyc[i] + 1) begin
          failures++;
          $display("FAIL basic_write%0d: addr=%0d data=%0h cyc=%0d required %0d %0h %0d",
                   i, wr_addr[i], wr_data[i], wr_cyc[i], i, d[i], hs_cyc[i] + 1);
        end
      end
      checks++;
      if (hs_cyc[3] != hs_cyc[0] + 3) begin
        failures++;
        $display("FAIL basic_throughput: last_hs=%0d required %0d", hs_cyc[3], hs_cyc[0] + 3);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != k + 2) begin
      failures++;
      $display("FAIL basic_done: dones=%0d at=%0d required 1 at %0d",
               done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, k + 2);
    end
    checks++;
    if (Count !== 11'd4 || Checksum !== 8'hAA) begin
      failures++;
      $display("FAIL basic_status: cnt=%0d sum=%0h required 4 aa", Count, Checksum);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d[4];
    int ea[4];
    d  = '{8'h80, 8'h80, 8'h01, 8'hFF};
    ea = '{1022, 1023, 0, 1};
    clear_logs();
    start_pulse(1022, 4);
    for (int i = 0; i < 4; i++) send_byte(d[i]);
    InValid = 1'b0;
    wait_idle();
    checks++;
    if (wr_addr.size() != 4) begin
      failures++;
      $display("FAIL wrap_count: writes=%0d required 4", wr_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[i] != ea[i] || wr_data[i] != int'(d[i])) begin
          failures++;
          $display("FAIL wrap_write%0d: addr=%0d data=%0h required %0d %0h",
                   i, wr_addr[i], wr_data[i], ea[i], d[i]);
        end
      end
    end
    checks++;
    if (Count !== 11'd4 || Checksum !== 8'h00) begin
      failures++;
      $display("FAIL wrap_status: cnt=%0d sum=%0h required 4 0", Count, Checksum);
    end
  endtask

  task automatic test_zero_back_to_back();
    clear_logs();
    start_pulse(3, 0);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b1 || InReady !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b busy=%b rdy=%b required 1 1 0", Done, Busy, InReady);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle: done=%b busy=%b required 0 0", Done, Busy);
    end
    // Start in the IDLE cycle straight after DONE.
    start_pulse(9, 0);
    checks++;
    if (Done !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_done: done=%b required 1", Done);
    end
    tick();
    tick();
    checks++;
    if (wr_addr.size() != 0 || done_cyc.size() != 2 || Count !== 11'd0) begin
      failures++;
      $display("FAIL zero_nowrite: writes=%0d dones=%0d cnt=%0d required 0 2 0",
               wr_addr.size(), done_cyc.size(), Count);
    end
  endtask

  task automatic test_clamp();
    int bad;
    clear_logs();
    start_pulse(5, 2000);
    for (int i = 0; i < 1024; i++) send_byte(8'(i));
    checks++;
    if (InReady !== 1'b0) begin
      failures++;
      $display("FAIL clamp_ready_drop: rdy=%b required 0", InReady);
    end
    repeat (3) tick();
    InValid = 1'b0;
    wait_idle();
    checks++;
    if (wr_addr.size() != 1024) begin
      failures++;
      $display("FAIL clamp_count: writes=%0d required 1024", wr_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
        if (wr_addr[i] != ((5 + i) % 1024) || wr_data[i] != (i % 256)) bad++;
      end
      checks++;
      if (bad != 0 || wr_addr[1023] != 4) begin
        failures++;
        $display("FAIL clamp_seq: bad=%0d last_addr=%0d required 0 4", bad, wr_addr[1023]);
      end
    end
    // Bytes 0..255 repeated four times sum to 4*32640, which is 0 mod 256.
    checks++;
    if (Count !== 11'd1024 || Checksum !== 8'h00 || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL clamp_status: cnt=%0d sum=%0h dones=%0d required 1024 0 1",
               Count, Checksum, done_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    logic       pat[6];
    logic [7:0] d[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    d   = '{8'hA1, 8'h5A, 8'h5B, 8'hB2, 8'h5C, 8'hC3};
    clear_logs();
    start_pulse(200, 3);
    for (int i = 0; i < 6; i++) begin
      InValid = pat[i];
      InData  = d[i];
      // A Start during LOAD must be ignored.
      if (i == 1) begin
        Start       = 1'b1;
        BaseAddress = 10'd100;
        Length      = 11'd7;
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    InValid = 1'b0;
    Start   = 1'b0;
    wait_idle();
    checks++;
    if (wr_addr.size() != 3 || hs_cyc.size() != 3) begin
      failures++;
      $display("FAIL bp_count: writes=%0d hs=%0d required 3 3", wr_addr.size(), hs_cyc.size());
    end else begin
      checks++;
      if (wr_addr[0] != 200 || wr_addr[1] != 201 || wr_addr[2] != 202 ||
          wr_data[0] != 'hA1 || wr_data[1] != 'hB2 || wr_data[2] != 'hC3) begin
        failures++;
        $display("FAIL bp_writes: a=%0d,%0d,%0d d=%0h,%0h,%0h required 200,201,202 a1,b2,c3",
                 wr_addr[0], wr_addr[1], wr_addr[2], wr_data[0], wr_data[1], wr_data[2]);
      end
      checks++;
      if (hs_cyc[1] != hs_cyc[0] + 3 || hs_cyc[2] != hs_cyc[0] + 5 ||
          wr_cyc[0] != hs_cyc[0] + 1 || wr_cyc[1] != hs_cyc[1] + 1 || wr_cyc[2] != hs_cyc[2] + 1) begin
        failures++;
        $display("FAIL bp_timing: hs=%0d,%0d,%0d wr=%0d,%0d,%0d required hs offsets 0,3,5 and wr=hs+1",
                 hs_cyc[0], hs_cyc[1], hs_cyc[2], wr_cyc[0], wr_cyc[1], wr_cyc[2]);
      end
    end
    checks++;
    if (Count !== 11'd3 || Checksum !== 8'h16 || done_cyc.size() != 1) begin
      failures++;
      $display("FAIL bp_status: cnt=%0d sum=%0h dones=%0d required 3 16 1", Count, Checksum, done_cyc.size());
    end
  endtask

  task automatic test_reset_midload();
    int n_before;
    clear_logs();
    start_pulse(50, 10);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    InValid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (WriteEnable !== 1'b0 || InReady !== 1'b0 || Busy !== 1'b0 || Count !== 11'd0) begin
      failures++;
      $display("FAIL midreset_async: we=%b rdy=%b busy=%b cnt=%0d required 0 0 0 0",
               WriteEnable, InReady, Busy, Count);
    end
    n_before = wr_addr.size();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (15) tick();
    checks++;
    if (done_cyc.size() != 0 || wr_addr.size() != n_before || Count !== 11'd0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abandon: dones=%0d writes=%0d cnt=%0d busy=%b required 0 %0d 0 0",
               done_cyc.size(), wr_addr.size(), Count, Busy, n_before);
    end
    clear_logs();
    start_pulse(7, 2);
    send_byte(8'h05);
    send_byte(8'h06);
    InValid = 1'b0;
    wait_idle();
    checks++;
    if (wr_addr.size() != 2 || done_cyc.size() != 1 || Count !== 11'd2 || Checksum !== 8'h0B) begin
      failures++;
      $display("FAIL midreset_reload: writes=%0d dones=%0d cnt=%0d sum=%0h required 2 1 2 0b",
               wr_addr.size(), done_cyc.size(), Count, Checksum);
    end else begin
      checks++;
      if (wr_addr[0] != 7 || wr_addr[1] != 8 || wr_data[0] != 5 || wr_data[1] != 6) begin
        failures++;
        $display("FAIL midreset_reload_writes: a=%0d,%0d d=%0h,%0h required 7,8 5,6",
                 wr_addr[0], wr_addr[1], wr_data[0], wr_data[1]);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    Start       = 1'b0;
    BaseAddress = '0;
    Length      = '0;
    InData      = '0;
    InValid     = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_back_to_back();
    test_clamp();
    test_backpressure();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_1w_loader.md
Name: sram_1w_loader

Overview:
Write-side loader for the 1024x8 input buffer SRAM. Accepts a byte stream over a valid/ready handshake and drives the SRAM write port (WriteAddress/WriteBus/WriteEnable) with sequential addresses from a programmable base, wrapping modulo 1024. Sits between the off-chip input interface and the buffer; the graph engine reads the buffer through the 1R port only after Done.

Parameters:
ADDR_W, 10, SRAM address width (depth = 2**ADDR_W = 1024)
DATA_W, 8, SRAM word width
LEN_W, 11, width of Length/Count (holds 0..1024)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
Start  input  1  begin a load; sampled only in IDLE
BaseAddress  input  10  first SRAM address, latched on accepted Start
Length  input  11  bytes to load, latched on accepted Start
InData  input  8  stream byte
InValid  input  1  InData valid
InReady  output  1  loader can accept a byte this cycle
WriteAddress  output  10  SRAM write address (registered)
WriteBus  output  8  SRAM write data (registered)
WriteEnable  output  1  SRAM write strobe (registered)
Busy  output  1  load in progress
Done  output  1  one-cycle pulse, load complete
Count  output  11  bytes accepted in current/last load
Checksum  output  8  sum of accepted bytes mod 256

Behaviour:
- Reset (reset_n=0, async): state IDLE; InReady, WriteEnable, Busy, Done = 0; WriteAddress, WriteBus, Count, Checksum = 0; internal remaining/pointer = 0. Reset mid-load abandons the load; no further writes; SRAM contents untouched.
- States: IDLE, LOAD, DONE.
- IDLE: InReady=0, Busy=0. Start=1 accepted: latch BaseAddress into pointer; remaining = min(Length,1024) (Length>1024 clamped to 1024); Count=0, Checksum=0. Next state LOAD if clamped length>0, else DONE.
- LOAD: Busy=1. InReady = (remaining != 0), from registered state only (no combinational path from InValid).
- Handshake: byte transferred when InValid & InReady at a rising edge. On transfer: WriteBus<=InData, WriteAddress<=pointer, WriteEnable<=1 next cycle; pointer<=pointer+1 mod 1024 (1023 -> 0); remaining--; Count++; Checksum<=Checksum+InData (8-bit wrap). Without transfer WriteEnable<=0; WriteAddress/WriteBus hold.
- Throughput: one byte per cycle with InValid held high; InValid gaps insert idle cycles, no data loss.
- Latency: handshake in cycle k -> WriteEnable=1 in cycle k+1.
- Completion: last handshake in cycle k; cycle k+1: remaining=0, InReady=0, final write issued, LOAD -> DONE; cycle k+2: DONE, Done=1, Busy=1; cycle k+3: IDLE, Busy=0.
- DONE: single cycle, Done=1, InReady=0, WriteEnable=0, -> IDLE.
- Length=0: Start cycle c, DONE in c+1 (Done=1), IDLE in c+2; no WriteEnable.
- Start while LOAD/DONE: ignored, no effect on latched values.
- Start in the IDLE cycle immediately after DONE: accepted.
- Count/Checksum hold after Done until next accepted Start.
- Readers must wait until Done; the SRAM read port has 4 ns output delay, which is the reader's concern, not this block's.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately, state IDLE; release, hold Start=0 10 cycles -> no WriteEnable.
- Basic: Base=0, Length=4, InData 0x11,0x22,0x33,0x44 with InValid continuous -> writes to addr 0,1,2,3 on consecutive cycles, each 1 cycle after handshake; Done 2 cycles after 4th handshake; Count=4, Checksum=0xAA.
- Wrap: Base=1022, Length=4, data 0x80,0x80,0x01,0xFF -> addresses 1022,1023,0,1; Checksum=0x00; Count=4.
- Zero/clamp: Length=0 -> Done 1 cycle after Start, no writes; Length=2000, Base=5 -> exactly 1024 writes, last to addr 4, Count=1024, InReady drops after 1024th handshake.
- Backpressure/ignore: Length=3, InValid toggled 1,0,0,1,0,1 -> 3 writes only on handshake cycles, correct order; Start=1 with Base=100 pulsed during LOAD -> ignored, addresses continue from original base.
- Reset mid-load: Length=10, reset_n=0 after 5 handshakes -> WriteEnable=0 at once, Done never pulses, Count=0; new load after reset completes normally.
